// File: rtl/mode_arbiter_pkg.sv
// Shared mode and FSM encodings for the mode arbiter, its datapath and requesters.
package mode_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'd0,
      MODE_INV  = 2'd1,
      MODE_ZERO = 2'd2,
      MODE_RSVD = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      ACK    = 2'd2
   } state_t;

endpackage

// File: rtl/mode_arbiter_if.sv
// Two-requester mode-change handshake bundle (req/req_mode held until ack).
interface mode_arbiter_if;
   import mode_pkg::*;

   logic  req0;
   mode_t req_mode0;
   logic  ack0;
   logic  req1;
   mode_t req_mode1;
   logic  ack1;

   modport master (output req0, req_mode0, req1, req_mode1, input ack0, ack1);
   modport slave  (input req0, req_mode0, req1, req_mode1, output ack0, ack1);

endinterface

// File: rtl/mode_arbiter_datapath.sv
// Combinational pass/invert/zero bit path with a blanking override.
module mode_datapath
   import mode_pkg::*;
(
   input  logic  a,
   input  mode_t mode,
   input  logic  blank,
   output logic  b
);

   always_comb begin
      b = 1'b0;
      if (!blank) begin
         unique case (mode)
            MODE_PASS: b = a;
            MODE_INV:  b = ~a;
            default:   b = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/mode_arbiter.sv
// Round-robin mode-change arbiter with settle blanking.
// Optional change counter enabled by MODE_ARBITER_STATS_EN.
module mode_arbiter
   import mode_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter mode_t       RESET_MODE    = MODE_INV
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           a,
   output logic           b,
   mode_arbiter_if.slave  arb,
   output logic [1:0]     cur_mode,
   output logic           busy
`ifdef MODE_ARBITER_STATS_EN
   ,
   output logic [15:0]    change_count
`endif
);

   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   mode_t      cur_mode_q, cur_mode_d;
   mode_t      pend_mode_q, pend_mode_d;
   logic       rr_ptr_q, rr_ptr_d;
   logic       gnt_q, gnt_d;
   logic       ack0_q, ack0_d;
   logic       ack1_q, ack1_d;
   logic [7:0] cnt_q, cnt_d;
   logic       gnt_sel;
   mode_t      gnt_mode;

   always_comb begin
      state_d     = state_q;
      cur_mode_d  = cur_mode_q;
      pend_mode_d = pend_mode_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      // With both requests high rr_ptr decides; otherwise the lone requester wins.
      gnt_sel     = (arb.req0 && arb.req1) ? rr_ptr_q : arb.req1;
      gnt_mode    = gnt_sel ? arb.req_mode1 : arb.req_mode0;

      unique case (state_q)
         IDLE: begin
            if (arb.req0 || arb.req1) begin
               gnt_d       = gnt_sel;
               rr_ptr_d    = ~gnt_sel;
               pend_mode_d = gnt_mode;
               if (gnt_mode == cur_mode_q) begin
                  state_d = ACK;
                  ack0_d  = ~gnt_sel;
                  ack1_d  = gnt_sel;
               end else begin
                  state_d = SETTLE;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         SETTLE: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               cur_mode_d = pend_mode_q;
               state_d    = ACK;
               ack0_d     = ~gnt_q;
               ack1_d     = gnt_q;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cur_mode_q  <= RESET_MODE;
         pend_mode_q <= RESET_MODE;
         rr_ptr_q    <= 1'b0;
         gnt_q       <= 1'b0;
         cnt_q       <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_mode_q  <= cur_mode_d;
         pend_mode_q <= pend_mode_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
      end
   end

`ifdef MODE_ARBITER_STATS_EN
   logic [15:0] change_count_q, change_count_d;

   always_comb begin
      change_count_d = change_count_q;
      if (state_q == SETTLE && cnt_q == 8'd0) change_count_d = change_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) change_count_q <= '0;
      else        change_count_q <= change_count_d;
   end

   assign change_count = change_count_q;
`endif

   mode_datapath u_dp (
      .a     (a),
      .mode  (cur_mode_q),
      .blank (state_q == SETTLE),
      .b     (b)
   );

   assign arb.ack0 = ack0_q;
   assign arb.ack1 = ack1_q;
   assign cur_mode = cur_mode_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mode_arbiter.sv
// Scoreboard bench for mode_arbiter; expected grants are queued at request time.
module tb_mode_arbiter;
   import mode_pkg::*;

   typedef struct packed {
      logic       id;
      logic [1:0] mode;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        a;
   logic        b;
   logic [1:0]  cur_mode;
   logic        busy;
`ifdef MODE_ARBITER_STATS_EN
   logic [15:0] change_count;
`endif

   int unsigned n_checks;
   int unsigned n_errors;
   exp_t        sb[$];
   logic [1:0]  exp_mode;
   int unsigned lat;
   int unsigned blanks;
   int unsigned acks_seen;

   mode_arbiter_if intf ();

   mode_arbiter #(
      .SETTLE_CYCLES (4),
      .RESET_MODE    (MODE_INV)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a            (a),
      .b            (b),
      .arb          (intf),
      .cur_mode     (cur_mode),
      .busy         (busy)
`ifdef MODE_ARBITER_STATS_EN
      ,
      .change_count (change_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic model_b(input logic ai, input logic [1:0] m);
      case (m)
         2'd0:    return ai;
         2'd1:    return ~ai;
         default: return 1'b0;
      endcase
   endfunction

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      exp_mode = MODE_INV;
   endtask

   task automatic raise(input logic id, input mode_t m);
      exp_t e;
      e.id   = id;
      e.mode = m;
      sb.push_back(e);
      if (id) begin intf.req1 = 1'b1; intf.req_mode1 = m; end
      else    begin intf.req0 = 1'b1; intf.req_mode0 = m; end
   endtask

   // Runs the handshake until every queued grant is acked or the budget expires.
   task automatic serve(input int unsigned budget, output int unsigned cycles, output int unsigned nblank);
      exp_t e;
      int unsigned bad;
      cycles = 0;
      nblank = 0;
      bad    = 0;
      while (sb.size() != 0 && cycles < budget) begin
         @(negedge clk);
         cycles++;
         a = 1'($urandom_range(0, 1));
         #1;
         if (intf.ack0 && intf.ack1) begin
            check_eq("ack_exclusive", 1, 0);
         end else if (intf.ack0 || intf.ack1) begin
            e = sb.pop_front();
            check_eq("ack_id", 32'(intf.ack1), 32'(e.id));
            check_eq("ack_mode", 32'(cur_mode), 32'(e.mode));
            exp_mode = e.mode;
            if (b !== model_b(a, exp_mode)) bad++;
            if (intf.ack0) intf.req0 = 1'b0;
            else           intf.req1 = 1'b0;
         end else if (busy) begin
            nblank++;
            if (b !== 1'b0) bad++;
         end else begin
            if (b !== model_b(a, exp_mode)) bad++;
         end
      end
      check_eq("sb_drained", sb.size(), 0);
      check_eq("b_bad_cycles", bad, 0);
      sb.delete();
   endtask

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      intf.req0      = 1'b0;
      intf.req1      = 1'b0;
      intf.req_mode0 = MODE_PASS;
      intf.req_mode1 = MODE_PASS;
      a              = 1'b1;
      rst_n          = 1'b0;
      exp_mode       = MODE_INV;

      // 1. reset state
      #12;
      check_eq("rst_cur_mode", 32'(cur_mode), 1);
      check_eq("rst_b_a1", 32'(b), 0);
      @(negedge clk);
      rst_n = 1'b1;
      a     = 1'b0;
      #1;
      check_eq("rst_b_a0", 32'(b), 1);
      check_eq("rst_ack0", 32'(intf.ack0), 0);
      check_eq("rst_ack1", 32'(intf.ack1), 0);
      check_eq("rst_busy", 32'(busy), 0);
`ifdef MODE_ARBITER_STATS_EN
      check_eq("rst_change_count", 32'(change_count), 0);
`endif

      // 2. real change INV -> PASS
      @(negedge clk);
      a = 1'b1;
      raise(1'b0, MODE_PASS);
      serve(50, lat, blanks);
      check_eq("chg_latency", lat, 5);
      check_eq("chg_blank_cycles", blanks, 4);

      // 3. fast path on requester 1
      @(negedge clk);
      raise(1'b1, MODE_PASS);
      serve(50, lat, blanks);
      check_eq("fast_latency", lat, 1);
      check_eq("fast_blank_cycles", blanks, 0);

      // 4. round robin, both raised together with rr_ptr=0
      @(negedge clk);
      apply_reset();
      raise(1'b0, MODE_ZERO);
      raise(1'b1, MODE_PASS);
      serve(100, lat, blanks);
      check_eq("rr_total_latency", lat, 11);
      check_eq("rr_blank_cycles", blanks, 8);
      check_eq("rr_final_mode", 32'(cur_mode), 0);

      // 5. reset during SETTLE with cnt=2
      @(negedge clk);
      raise(1'b0, MODE_ZERO);
      sb.delete();
      repeat (2) @(negedge clk);
      check_eq("mid_busy_before", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_busy", 32'(busy), 0);
      check_eq("mid_cur_mode", 32'(cur_mode), 1);
      check_eq("mid_ack0", 32'(intf.ack0), 0);
      intf.req0 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      exp_mode  = MODE_INV;
      acks_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (intf.ack0 || intf.ack1) acks_seen++;
      end
      check_eq("mid_no_ack", acks_seen, 0);
      check_eq("mid_cur_mode_after", 32'(cur_mode), 1);

`ifdef MODE_ARBITER_STATS_EN
      // 6. three real changes plus two fast-path acks, then wrap
      apply_reset();
      @(negedge clk); raise(1'b0, MODE_PASS); serve(50, lat, blanks);
      @(negedge clk); raise(1'b1, MODE_PASS); serve(50, lat, blanks);
      @(negedge clk); raise(1'b0, MODE_ZERO); serve(50, lat, blanks);
      @(negedge clk); raise(1'b1, MODE_ZERO); serve(50, lat, blanks);
      @(negedge clk); raise(1'b0, MODE_INV);  serve(50, lat, blanks);
      check_eq("stats_count", 32'(change_count), 3);
      @(negedge clk);
      force dut.change_count_q = 16'hFFFF;
      #1;
      release dut.change_count_q;
      @(negedge clk); raise(1'b1, MODE_PASS); serve(50, lat, blanks);
      check_eq("stats_wrap", 32'(change_count), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
